window_feeder: RTL and testbench

Streaming line-buffer front end for the convolution PE array. It accepts a raster-order pixel stream, holds the previous `KERNEL_SIZE-1` image rows in on-chip line buffers, and emits one vertical column of `KERNEL_SIZE` pixels per accepted pixel. Each column is formatted for direct connection to the PE array's `dataIn`/`en` pair. Frame position and a frame-done pulse travel with the columns so downstream sum/output logic can align results.

---
 rtl/window_feeder.sv | 129 ++++++++++++
 tb/tb_window_feeder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_feeder.sv
// Streaming line-buffer front end: turns a raster pixel stream into vertical
// KERNEL_SIZE-pixel columns for the PE array, tagged with frame position.
module window_feeder #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 32,
  parameter int unsigned IMG_HEIGHT  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               pix_in,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic                                ds_ready,
  output logic [DATA_WIDTH*KERNEL_SIZE-1:0]   col_out,
  output logic                                col_en,
  output logic [$clog2(IMG_WIDTH)-1:0]        col_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]       col_y,
  output logic                                frame_done
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam int unsigned CW = DATA_WIDTH * KERNEL_SIZE;
  localparam int unsigned LB = KERNEL_SIZE - 1;

  typedef enum logic [1:0] {FILL, STREAM, DONE} state_e;

  state_e                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [CW-1:0]           col_q, col_d;
  logic                    col_en_q, col_en_d;
  logic [XW-1:0]           col_x_q, col_x_d;
  logic [YW-1:0]           col_y_q, col_y_d;
  logic                    frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0]   lb_q [LB][IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   lb_d [LB][IMG_WIDTH];

  logic acc;
  logic row_end;

  assign pix_ready = ds_ready && (state_q != DONE) && !rst;
  assign acc       = pix_valid && pix_ready;
  assign row_end   = (x_q == XW'(IMG_WIDTH - 1));

  // Position counters, line-buffer shift, column assembly and frame FSM.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    lb_d         = lb_q;
    col_d        = col_q;
    col_en_d     = 1'b0;
    col_x_d      = col_x_q;
    col_y_d      = col_y_q;
    frame_done_d = 1'b0;

    if (acc) begin
      x_d = row_end ? '0 : x_q + XW'(1);
      if (row_end) y_d = y_q + YW'(1);
      lb_d[0][x_q] = pix_in;
      for (int unsigned j = 1; j < LB; j++) lb_d[j][x_q] = lb_q[j-1][x_q];
    end

    case (state_q)
      FILL: begin
        if (acc && row_end && (y_q == YW'(KERNEL_SIZE - 2))) state_d = STREAM;
      end
      STREAM: begin
        if (acc) begin
          col_en_d = 1'b1;
          col_x_d  = x_q;
          col_y_d  = y_q;
          col_d[CW-DATA_WIDTH +: DATA_WIDTH] = pix_in;
          // Older rows sit in deeper buffers, so they land in lower slots.
          for (int unsigned j = 0; j < LB; j++)
            col_d[(LB-1-j)*DATA_WIDTH +: DATA_WIDTH] = lb_q[j][x_q];
          if (row_end && (y_q == YW'(IMG_HEIGHT - 1))) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            x_d          = '0;
            y_d          = '0;
          end
        end
      end
      DONE: begin
        state_d = FILL;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      col_en_q     <= 1'b0;
      col_x_q      <= '0;
      col_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      col_en_q     <= col_en_d;
      col_x_q      <= col_x_d;
      col_y_q      <= col_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers carry no reset; FILL rewrites them before they are read.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

  assign col_out    = col_q;
  assign col_en     = col_en_q;
  assign col_x      = col_x_q;
  assign col_y      = col_y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder with K=3, W=H=4; expected columns are
// computed from the pixel formula base+16*y+x.
module tb_window_feeder;

  localparam int K = 3;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        ds_ready;
  logic [23:0] col_out;
  logic        col_en;
  logic [1:0]  col_x;
  logic [1:0]  col_y;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [23:0] q_col[$];
  int          q_x[$];
  int          q_y[$];
  int          q_fd[$];
  int          q_cyc[$];
  int          acc_cyc[$];

  window_feeder #(.KERNEL_SIZE(K), .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ds_ready(ds_ready), .col_out(col_out), .col_en(col_en), .col_x(col_x),
    .col_y(col_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Column log, sampled on the falling edge.
  always @(negedge clk) begin
    if (col_en === 1'b1) begin
      q_col.push_back(col_out);
      q_x.push_back(int'(col_x));
      q_y.push_back(int'(col_y));
      q_fd.push_back(int'(frame_done));
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [23:0] exp_col(input int base, input int x, input int y);
    logic [7:0] s0, s1, s2;
    s0 = 8'(base + 16*(y-2) + x);
    s1 = 8'(base + 16*(y-1) + x);
    s2 = 8'(base + 16*y + x);
    return {s2, s1, s0};
  endfunction

  task automatic clear_log();
    q_col.delete(); q_x.delete(); q_y.delete(); q_fd.delete(); q_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      ds_ready  = 1'b1;
    end
  endtask

  // Feeds npix pixels in raster order; counts cycles where pix_ready was low.
  task automatic feed(input int base, input int npix, input int stall_idx, input int stall_len,
                      input bit gaps, output int nlow, output int nlow_bad);
    int idx;
    int stall;
    int budget;
    bit stall_done;
    idx = 0; stall = 0; budget = 0; stall_done = 1'b0;
    nlow = 0; nlow_bad = 0;
    while (idx < npix && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (!stall_done && idx == stall_idx) begin
        stall = stall_len;
        stall_done = 1'b1;
      end
      ds_ready = (stall == 0);
      if (stall > 0) stall--;
      pix_valid = 1'b1;
      pix_in = 8'(base + 16*(idx / W) + (idx % W));
      #1;
      if (pix_ready !== 1'b1) begin
        nlow++;
        if (ds_ready) nlow_bad++;
      end else begin
        acc_cyc.push_back(cyc);
        idx++;
        if (gaps && idx < npix) begin
          @(negedge clk);
          pix_valid = 1'b0;
          ds_ready  = 1'b1;
        end
      end
    end
    if (idx < npix) begin
      checks++; errors++;
      $display("FAIL feed_timeout accepted %0d of %0d pixels", idx, npix);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; ds_ready = 1'b1; pix_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({col_en, frame_done, col_out, col_x, col_y} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b fd=%b col=%h x=%0d y=%0d want all 0",
               col_en, frame_done, col_out, col_x, col_y);
    end
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++; $display("FAIL reset_pix_ready got %b want 0", pix_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_pix_ready got %b want 1", pix_ready);
    end
  endtask

  task automatic test_basic_fill(input string tag);
    int nlow, nbad;
    clear_log();
    feed(0, W*H, -1, 0, 1'b0, nlow, nbad);
    @(negedge clk);
    pix_valid = 1'b0;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++; $display("FAIL %s done_pix_ready got %b want 0", tag, pix_ready);
    end
    idle(3);
    checks++;
    if (nlow != 0) begin
      errors++; $display("FAIL %s ready_low got %0d want 0", tag, nlow);
    end
    checks++;
    if (q_col.size() != 8) begin
      errors++; $display("FAIL %s col_count got %0d want 8", tag, q_col.size());
    end else begin
      checks++;
      if (q_cyc[0] != acc_cyc[8] + 1) begin
        errors++; $display("FAIL %s first_col_cycle got %0d want %0d", tag, q_cyc[0], acc_cyc[8] + 1);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_col[i] !== exp_col(0, i % W, 2 + i / W) || q_x[i] != i % W || q_y[i] != 2 + i / W
            || q_fd[i] != ((i == 7) ? 1 : 0)) begin
          errors++;
          $display("FAIL %s col[%0d] got %h x=%0d y=%0d fd=%0d want %h x=%0d y=%0d fd=%0d", tag, i,
                   q_col[i], q_x[i], q_y[i], q_fd[i], exp_col(0, i % W, 2 + i / W), i % W, 2 + i / W,
                   (i == 7) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nlow, nbad;
    clear_log();
    feed(0, W*H, 9, 3, 1'b0, nlow, nbad);
    idle(4);
    checks++;
    if (nlow != 3 || nbad != 0) begin
      errors++; $display("FAIL bp_ready_low got %0d (unexpected %0d) want 3 (0)", nlow, nbad);
    end
    checks++;
    if (q_col.size() != 8) begin
      errors++; $display("FAIL bp_col_count got %0d want 8", q_col.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_col[i] !== exp_col(0, i % W, 2 + i / W) || q_x[i] != i % W || q_y[i] != 2 + i / W
            || q_fd[i] != ((i == 7) ? 1 : 0)) begin
          errors++;
          $display("FAIL bp_col[%0d] got %h x=%0d y=%0d fd=%0d want %h", i, q_col[i], q_x[i],
                   q_y[i], q_fd[i], exp_col(0, i % W, 2 + i / W));
        end
      end
    end
  endtask

  task automatic test_valid_gaps();
    int nlow, nbad;
    clear_log();
    feed(0, W*H, -1, 0, 1'b1, nlow, nbad);
    idle(4);
    checks++;
    if (q_col.size() != 8) begin
      errors++; $display("FAIL gap_col_count got %0d want 8", q_col.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_col[i] !== exp_col(0, i % W, 2 + i / W) || q_x[i] != i % W || q_y[i] != 2 + i / W
            || q_cyc[i] != acc_cyc[i + 8] + 1) begin
          errors++;
          $display("FAIL gap_col[%0d] got %h x=%0d y=%0d cyc=%0d want %h x=%0d y=%0d cyc=%0d", i,
                   q_col[i], q_x[i], q_y[i], q_cyc[i], exp_col(0, i % W, 2 + i / W), i % W,
                   2 + i / W, acc_cyc[i + 8] + 1);
        end
        if (i > 0) begin
          checks++;
          if (q_cyc[i] - q_cyc[i-1] != 2) begin
            errors++; $display("FAIL gap_spacing[%0d] got %0d want 2", i, q_cyc[i] - q_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nlow1, nbad1, nlow2, nbad2;
    clear_log();
    feed(0, W*H, -1, 0, 1'b0, nlow1, nbad1);
    feed(8'h80, W*H, -1, 0, 1'b0, nlow2, nbad2);
    idle(4);
    checks++;
    if (nlow1 != 0 || nlow2 != 1 || nbad2 != 1) begin
      errors++;
      $display("FAIL b2b_ready_low got f1=%0d f2=%0d want f1=0 f2=1", nlow1, nlow2);
    end
    checks++;
    if (q_col.size() != 16) begin
      errors++; $display("FAIL b2b_col_count got %0d want 16", q_col.size());
    end else begin
      checks++;
      if (q_col[8] !== 24'hA09080) begin
        errors++; $display("FAIL b2b_first_col got %h want a09080", q_col[8]);
      end
      checks++;
      if (q_cyc[8] - q_cyc[7] != 10) begin
        errors++; $display("FAIL b2b_gap got %0d want 10", q_cyc[8] - q_cyc[7]);
      end
      for (int i = 8; i < 16; i++) begin
        checks++;
        if (q_col[i] !== exp_col(8'h80, (i-8) % W, 2 + (i-8) / W) || q_fd[i] != ((i == 15) ? 1 : 0)) begin
          errors++;
          $display("FAIL b2b_col[%0d] got %h fd=%0d want %h", i, q_col[i], q_fd[i],
                   exp_col(8'h80, (i-8) % W, 2 + (i-8) / W));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nlow, nbad;
    clear_log();
    feed(0, 10, -1, 0, 1'b0, nlow, nbad);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = 8'h22;
    rst       = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_pix_ready got %b want 0", pix_ready);
    end
    @(negedge clk);
    checks++;
    if ({col_en, frame_done, col_out, col_x, col_y} !== 29'd0) begin
      errors++;
      $display("FAIL mid_rst_outputs got en=%b fd=%b col=%h x=%0d y=%0d want all 0",
               col_en, frame_done, col_out, col_x, col_y);
    end
    rst = 1'b0;
    pix_valid = 1'b0;
    test_basic_fill("restart");
  endtask

  initial begin
    test_reset();
    test_basic_fill("basic");
    test_backpressure();
    test_valid_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
